// File: rtl/matrix_mult_4x4_complex_stream_ctrl.sv
// rtl/matrix_mult_4x4_complex_stream_ctrl.sv - streaming load/compute/drain wrapper around a 4x4 complex Strassen multiplier
//
// matrix_mult_4x4_complex_strassen
//   Combinational C = A * B on 4x4 complex matrices. One Strassen level over 2x2 blocks
//   (7 block products), each block product done directly.
//   a_re/a_im/b_re/b_im : [4][4] signed w-bit operands
//   c_re/c_im           : [4][4] signed WIDTH_OUT-bit results
//
// matrix_mult_4x4_complex_stream_ctrl
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     : input element handshake; in_re/in_im carry A then B, row-major
//   out_valid/out_ready   : output element handshake; out_re/out_im carry C row-major
//   out_row/out_col       : index of the element currently on out_re/out_im
//   out_last              : marks C[3][3]
//   busy                  : high while computing or draining
//   job_count/stall_count : present only when STREAM_CTRL_PERF_EN is defined

module matrix_mult_4x4_complex_strassen #(
    parameter int w         = 48,
    parameter int WIDTH_OUT = 2*w+3
) (
    input  logic signed [w-1:0]         a_re [4][4],
    input  logic signed [w-1:0]         a_im [4][4],
    input  logic signed [w-1:0]         b_re [4][4],
    input  logic signed [w-1:0]         b_im [4][4],
    output logic signed [WIDTH_OUT-1:0] c_re [4][4],
    output logic signed [WIDTH_OUT-1:0] c_im [4][4]
);

    typedef logic signed [WIDTH_OUT-1:0] val_t;

    // Every intermediate lives at the full output width. Arithmetic is modular there, and
    // the true result fits, so the intermediate growth of Strassen's sums cannot corrupt it.
    val_t ea_re [4][4];
    val_t ea_im [4][4];
    val_t eb_re [4][4];
    val_t eb_im [4][4];
    val_t la_re [7][2][2];
    val_t la_im [7][2][2];
    val_t lb_re [7][2][2];
    val_t lb_im [7][2][2];
    val_t m_re  [7][2][2];
    val_t m_im  [7][2][2];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                ea_re[i][j] = {{(WIDTH_OUT-w){a_re[i][j][w-1]}}, a_re[i][j]};
                ea_im[i][j] = {{(WIDTH_OUT-w){a_im[i][j][w-1]}}, a_im[i][j]};
                eb_re[i][j] = {{(WIDTH_OUT-w){b_re[i][j][w-1]}}, b_re[i][j]};
                eb_im[i][j] = {{(WIDTH_OUT-w){b_im[i][j][w-1]}}, b_im[i][j]};
            end
        end
    end

    always_comb begin
        la_re = '{default: '0};
        la_im = '{default: '0};
        lb_re = '{default: '0};
        lb_im = '{default: '0};
        m_re  = '{default: '0};
        m_im  = '{default: '0};
        c_re  = '{default: '0};
        c_im  = '{default: '0};
        // Block (p,q) element (i,j) is matrix element [2p+i][2q+j].
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                // M1 = (A11+A22)(B11+B22)
                la_re[0][i][j] = ea_re[i][j] + ea_re[i+2][j+2];
                la_im[0][i][j] = ea_im[i][j] + ea_im[i+2][j+2];
                lb_re[0][i][j] = eb_re[i][j] + eb_re[i+2][j+2];
                lb_im[0][i][j] = eb_im[i][j] + eb_im[i+2][j+2];
                // M2 = (A21+A22)B11
                la_re[1][i][j] = ea_re[i+2][j] + ea_re[i+2][j+2];
                la_im[1][i][j] = ea_im[i+2][j] + ea_im[i+2][j+2];
                lb_re[1][i][j] = eb_re[i][j];
                lb_im[1][i][j] = eb_im[i][j];
                // M3 = A11(B12-B22)
                la_re[2][i][j] = ea_re[i][j];
                la_im[2][i][j] = ea_im[i][j];
                lb_re[2][i][j] = eb_re[i][j+2] - eb_re[i+2][j+2];
                lb_im[2][i][j] = eb_im[i][j+2] - eb_im[i+2][j+2];
                // M4 = A22(B21-B11)
                la_re[3][i][j] = ea_re[i+2][j+2];
                la_im[3][i][j] = ea_im[i+2][j+2];
                lb_re[3][i][j] = eb_re[i+2][j] - eb_re[i][j];
                lb_im[3][i][j] = eb_im[i+2][j] - eb_im[i][j];
                // M5 = (A11+A12)B22
                la_re[4][i][j] = ea_re[i][j] + ea_re[i][j+2];
                la_im[4][i][j] = ea_im[i][j] + ea_im[i][j+2];
                lb_re[4][i][j] = eb_re[i+2][j+2];
                lb_im[4][i][j] = eb_im[i+2][j+2];
                // M6 = (A21-A11)(B11+B12)
                la_re[5][i][j] = ea_re[i+2][j] - ea_re[i][j];
                la_im[5][i][j] = ea_im[i+2][j] - ea_im[i][j];
                lb_re[5][i][j] = eb_re[i][j] + eb_re[i][j+2];
                lb_im[5][i][j] = eb_im[i][j] + eb_im[i][j+2];
                // M7 = (A12-A22)(B21+B22)
                la_re[6][i][j] = ea_re[i][j+2] - ea_re[i+2][j+2];
                la_im[6][i][j] = ea_im[i][j+2] - ea_im[i+2][j+2];
                lb_re[6][i][j] = eb_re[i+2][j] + eb_re[i+2][j+2];
                lb_im[6][i][j] = eb_im[i+2][j] + eb_im[i+2][j+2];
            end
        end
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    m_re[k][i][j] = la_re[k][i][0] * lb_re[k][0][j] - la_im[k][i][0] * lb_im[k][0][j]
                                  + la_re[k][i][1] * lb_re[k][1][j] - la_im[k][i][1] * lb_im[k][1][j];
                    m_im[k][i][j] = la_re[k][i][0] * lb_im[k][0][j] + la_im[k][i][0] * lb_re[k][0][j]
                                  + la_re[k][i][1] * lb_im[k][1][j] + la_im[k][i][1] * lb_re[k][1][j];
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                c_re[i][j]     = m_re[0][i][j] + m_re[3][i][j] - m_re[4][i][j] + m_re[6][i][j];
                c_im[i][j]     = m_im[0][i][j] + m_im[3][i][j] - m_im[4][i][j] + m_im[6][i][j];
                c_re[i][j+2]   = m_re[2][i][j] + m_re[4][i][j];
                c_im[i][j+2]   = m_im[2][i][j] + m_im[4][i][j];
                c_re[i+2][j]   = m_re[1][i][j] + m_re[3][i][j];
                c_im[i+2][j]   = m_im[1][i][j] + m_im[3][i][j];
                c_re[i+2][j+2] = m_re[0][i][j] - m_re[1][i][j] + m_re[2][i][j] + m_re[5][i][j];
                c_im[i+2][j+2] = m_im[0][i][j] - m_im[1][i][j] + m_im[2][i][j] + m_im[5][i][j];
            end
        end
    end

endmodule

module matrix_mult_4x4_complex_stream_ctrl #(
    parameter int w         = 48,
    parameter int WIDTH_OUT = 2*w+3,
    parameter int MUL_LAT   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [w-1:0]         in_re,
    input  logic signed [w-1:0]         in_im,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH_OUT-1:0] out_re,
    output logic signed [WIDTH_OUT-1:0] out_im,
    output logic [1:0]                  out_row,
    output logic [1:0]                  out_col,
    output logic                        out_last,
    output logic                        busy
`ifdef STREAM_CTRL_PERF_EN
    ,
    output logic [15:0]                 job_count,
    output logic [15:0]                 stall_count
`endif
);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [4:0] idx;
    logic [3:0] cnt;

    logic signed [w-1:0]         a_re [4][4];
    logic signed [w-1:0]         a_im [4][4];
    logic signed [w-1:0]         b_re [4][4];
    logic signed [w-1:0]         b_im [4][4];
    logic signed [WIDTH_OUT-1:0] c_re [4][4];
    logic signed [WIDTH_OUT-1:0] c_im [4][4];
    logic signed [WIDTH_OUT-1:0] p_re [4][4];
    logic signed [WIDTH_OUT-1:0] p_im [4][4];

    logic in_fire, out_fire, settle_done;

    matrix_mult_4x4_complex_strassen #(
        .w         (w),
        .WIDTH_OUT (WIDTH_OUT)
    ) u_mult (
        .a_re (a_re),
        .a_im (a_im),
        .b_re (b_re),
        .b_im (b_im),
        .c_re (p_re),
        .c_im (p_im)
    );

    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign settle_done = (cnt == 4'(MUL_LAT-1));

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_re    = '0;
        out_im    = '0;
        out_row   = 2'd0;
        out_col   = 2'd0;
        out_last  = 1'b0;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && idx == 5'd31) begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (settle_done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_re    = c_re[idx[3:2]][idx[1:0]];
                out_im    = c_im[idx[3:2]][idx[1:0]];
                out_row   = idx[3:2];
                out_col   = idx[1:0];
                out_last  = (idx == 5'd15);
                if (out_ready && idx == 5'd15) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            idx     <= 5'd0;
            cnt     <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    a_re[i][j] <= '0;
                    a_im[i][j] <= '0;
                    b_re[i][j] <= '0;
                    b_im[i][j] <= '0;
                    c_re[i][j] <= '0;
                    c_im[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                LOAD: begin
                    if (in_fire) begin
                        if (!idx[4]) begin
                            a_re[idx[3:2]][idx[1:0]] <= in_re;
                            a_im[idx[3:2]][idx[1:0]] <= in_im;
                        end else begin
                            b_re[idx[3:2]][idx[1:0]] <= in_re;
                            b_im[idx[3:2]][idx[1:0]] <= in_im;
                        end
                        // 5-bit wrap takes idx from 31 back to 0 on the final element.
                        idx <= idx + 5'd1;
                        cnt <= 4'd0;
                    end
                end
                COMPUTE: begin
                    cnt <= cnt + 4'd1;
                    if (settle_done) begin
                        c_re <= p_re;
                        c_im <= p_im;
                        idx  <= 5'd0;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        idx <= (idx == 5'd15) ? 5'd0 : idx + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef STREAM_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            job_count   <= 16'd0;
            stall_count <= 16'd0;
        end else begin
            if (out_fire && out_last) begin
                job_count <= job_count + 16'd1;
            end
            if (out_valid && !out_ready && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/matrix_mult_4x4_complex_stream_ctrl.md
Name: matrix_mult_4x4_complex_stream_ctrl

Overview:
Streaming front/back end for the combinational 4x4 complex Strassen multiplier (matrix_mult_4x4_complex_strassen, instantiated inside). Accepts A and B one complex element per handshake, holds them in register banks and drives the multiplier. After a fixed multicycle settling window it captures C and streams it out one complex element per handshake. It is the hardware producer/consumer of the multiplier's parallel matrix ports, for placement behind a bus or DMA.

Parameters:
w, 48, operand width per real/imag component (signed)
WIDTH_OUT, 2*w+3, result width per component (signed)
MUL_LAT, 2, cycles allowed for the combinational multiplier to settle (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input element valid
in_ready  out  1  input element accepted when in_valid&&in_ready
in_re  in  w  signed real part
in_im  in  w  signed imaginary part
out_valid  out  1  output element valid
out_ready  in  1  downstream accepts
out_re  out  WIDTH_OUT  signed real part of C element
out_im  out  WIDTH_OUT  signed imaginary part of C element
out_row  out  2  row index of current C element
out_col  out  2  column index of current C element
out_last  out  1  high with element C[3][3]
busy  out  1  high in COMPUTE and DRAIN

Behaviour:
- States: LOAD, COMPUTE, DRAIN. Reset -> LOAD, idx=0, all A/B/C registers 0, in_ready=1, out_valid=0, out_re/out_im/out_row/out_col/out_last=0, busy=0.
- LOAD: in_ready=1. Each handshake writes element idx (5-bit). idx 0..15 -> A[idx>>2][idx&3], idx 16..31 -> B[(idx-16)>>2][(idx-16)&3], row-major. Handshake at idx=31 -> COMPUTE, cnt=0, in_ready=0 next cycle. in_valid low: no change.
- COMPUTE: in_ready=0, out_valid=0. cnt increments each edge. At the edge where cnt==MUL_LAT-1, the multiplier outputs are captured into C, the state goes to DRAIN and idx resets to 0. out_valid therefore rises exactly MUL_LAT edges after the idx=31 input handshake.
- DRAIN: out_valid=1. out_re/out_im=C[idx>>2][idx&3]. out_row=idx>>2, out_col=idx&3, out_last=(idx==15). Outputs hold stable while out_ready=0. Handshake advances idx. The handshake at idx=15 -> LOAD, idx=0, out_valid=0, in_ready=1 next cycle.
- No overlap: input is never accepted while busy. in_valid outside LOAD is ignored.
- A and B registers are not modified outside LOAD. The multiplier inputs stay constant through COMPUTE.
- Arithmetic: exact two's complement; full product sum fits in WIDTH_OUT, with no saturation or truncation.
- Reset asserted at any time (mid-LOAD, COMPUTE or DRAIN) aborts immediately to reset state. The partial job is discarded and never emitted.

Optional Feature:
STREAM_CTRL_PERF_EN: defined -> adds output ports job_count (16 bits, +1 on each out_last handshake, wraps 0xFFFF->0) and stall_count (16 bits, +1 each cycle with out_valid&&!out_ready, saturates at 0xFFFF). Both reset to 0. Undefined -> ports and counters absent, behaviour otherwise identical.

Test Plan:
- A=I (real), B_re[i][j]=4i+j, B_im[i][j]=-(4i+j), out_ready=1 -> C equals B. out_valid rises 2 edges after the 32nd handshake. 16 outputs on consecutive cycles with out_row/out_col row-major and out_last only on the 16th.
- All A and B elements = 1+1i -> every C element re=0, im=8.
- All A_re and B_re = -2^47, imag 0 (w=48) -> every C_re = 2^96 (no overflow), C_im = 0.
- out_ready pattern 1,0,0,1,0,1... during DRAIN -> each element emitted exactly once, data/row/col stable while stalled, order preserved.
- rst_n pulsed low after 10 input handshakes, then a full 32-element job (identity test) -> in_ready=1 right after reset, out_valid never asserted before the new job completes, result matches the identity test.
- With STREAM_CTRL_PERF_EN: 3 back-to-back jobs with 5 total stall cycles -> job_count=3, stall_count=5.
